// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit -- Ak-16b pipelined control unit.
//
// Decodes the ID-stage opcode into a control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB registers. Detects RAW / load-use hazards
// against the EX and MEM stages, raising stall, and converts a taken
// branch/jump resolved in EX into a flush of the IF/ID contents.
//
// Build option: define CTRL_FWD_EN to enable operand forwarding selects.
//   With CTRL_FWD_EN    : only load-use stalls; fwd_a/fwd_b ports exist.
//   Without CTRL_FWD_EN : any hazard in EX or MEM stalls until the producer
//                         reaches WB (register file is write-then-read).
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_opcode         ID opcode
//   id_rs1/rs2/rd     ID register fields
//   ex_taken          branch/jump in EX resolved taken
//   stall, flush      combinational pipeline control (flush wins)
//   ex_*              EX-stage control bundle
//   mem_*             MEM-stage control bundle
//   wb_*              WB-stage control bundle
//   fwd_a, fwd_b      forward selects, 0=RF 1=EX/MEM 2=MEM/WB (CTRL_FWD_EN)

module pipe_ctrl_unit #(
  parameter int OPC_W    = 4,
  parameter int RA_W     = 3,
  parameter int ALUOP_W  = 4,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OPC_W-1:0]   id_opcode,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               ex_taken,
  output logic               stall,
  output logic               flush,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic [1:0]         ex_branch,
  output logic [RA_W-1:0]    ex_rd,
  output logic               mem_read,
  output logic               mem_write,
  output logic [RA_W-1:0]    mem_rd,
  output logic               mem_reg_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [RA_W-1:0]    wb_rd
`ifdef CTRL_FWD_EN
  ,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
`endif
);

  // Ak-16b opcode encoding
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_XORI = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(15);

  // ALU operation encoding
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JUMP = 2'd3;

  // A source register depends on a producer when the producer writes the
  // same register; r0 is hard-wired so it never creates a dependency.
  function automatic logic raw_match(input logic [RA_W-1:0] src,
                                     input logic            use_src,
                                     input logic [RA_W-1:0] prod_rd,
                                     input logic            prod_wr);
    raw_match = use_src && prod_wr && (src == prod_rd) &&
                !((ZERO_REG != 0) && (src == '0));
  endfunction

  // Decoded control bundle for the ID instruction
  logic               dec_vld;
  logic               dec_reg_write;
  logic               dec_mem_read;
  logic               dec_mem_write;
  logic               dec_mem_to_reg;
  logic               dec_alu_src;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic [1:0]         dec_branch;
  logic               dec_use_rs1;
  logic               dec_use_rs2;

  // EX stage
  logic               vld_p0;
  logic [ALUOP_W-1:0] alu_op_p0;
  logic               alu_src_p0;
  logic [1:0]         branch_p0;
  logic [RA_W-1:0]    rd_p0;
  logic               reg_write_p0;
  logic               mem_read_p0;
  logic               mem_write_p0;
  logic               mem_to_reg_p0;

  // MEM stage
  logic               vld_p1;
  logic [RA_W-1:0]    rd_p1;
  logic               reg_write_p1;
  logic               mem_read_p1;
  logic               mem_write_p1;
  logic               mem_to_reg_p1;

  // WB stage
  logic [RA_W-1:0]    rd_p2;
  logic               reg_write_p2;
  logic               mem_to_reg_p2;

  logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic hazard_stall;
  logic branch_flush;
  logic issue;

  always_comb begin
    dec_vld        = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_branch     = BR_NONE;
    dec_use_rs1    = 1'b0;
    dec_use_rs2    = 1'b0;
    case (id_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        dec_vld       = 1'b1;
        dec_reg_write = 1'b1;
        dec_use_rs1   = 1'b1;
        dec_use_rs2   = 1'b1;
        case (id_opcode)
          OP_SUB:  dec_alu_op = ALU_SUB;
          OP_AND:  dec_alu_op = ALU_AND;
          OP_OR:   dec_alu_op = ALU_OR;
          OP_XOR:  dec_alu_op = ALU_XOR;
          OP_SLT:  dec_alu_op = ALU_SLT;
          default: dec_alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_vld       = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_use_rs1   = 1'b1;
        case (id_opcode)
          OP_ANDI: dec_alu_op = ALU_AND;
          OP_ORI:  dec_alu_op = ALU_OR;
          OP_XORI: dec_alu_op = ALU_XOR;
          default: dec_alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        dec_vld        = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_src    = 1'b1;
        dec_alu_op     = ALU_ADD;
        dec_use_rs1    = 1'b1;
      end
      OP_SW: begin
        dec_vld       = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_op    = ALU_ADD;
        dec_use_rs1   = 1'b1;
        dec_use_rs2   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_vld     = 1'b1;
        dec_branch  = (id_opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
        dec_alu_op  = ALU_SUB;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
      end
      OP_J: begin
        dec_vld    = 1'b1;
        dec_branch = BR_JUMP;
      end
      OP_JAL: begin
        dec_vld       = 1'b1;
        dec_branch    = BR_JUMP;
        dec_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Producers sitting in EX and MEM; WB is covered by the write-first RF.
  assign ex_hit_rs1  = vld_p0 && raw_match(id_rs1, dec_use_rs1, rd_p0, reg_write_p0);
  assign ex_hit_rs2  = vld_p0 && raw_match(id_rs2, dec_use_rs2, rd_p0, reg_write_p0);
  assign mem_hit_rs1 = vld_p1 && raw_match(id_rs1, dec_use_rs1, rd_p1, reg_write_p1);
  assign mem_hit_rs2 = vld_p1 && raw_match(id_rs2, dec_use_rs2, rd_p1, reg_write_p1);

`ifdef CTRL_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is
  // bypassed, with the younger EX/MEM result taking priority.
  logic [1:0] fwd_a_nxt, fwd_b_nxt;
  logic [1:0] fwd_a_p0, fwd_b_p0;

  assign hazard_stall = id_valid && mem_read_p0 && (ex_hit_rs1 || ex_hit_rs2);

  always_comb begin
    fwd_a_nxt = 2'd0;
    fwd_b_nxt = 2'd0;
    if (ex_hit_rs1)       fwd_a_nxt = 2'd1;
    else if (mem_hit_rs1) fwd_a_nxt = 2'd2;
    if (ex_hit_rs2)       fwd_b_nxt = 2'd1;
    else if (mem_hit_rs2) fwd_b_nxt = 2'd2;
  end
`else
  // No bypass network: hold ID until every producer has reached WB.
  assign hazard_stall = id_valid &&
                        (ex_hit_rs1 || ex_hit_rs2 || mem_hit_rs1 || mem_hit_rs2);
`endif

  // A taken branch/jump kills the wrong-path ID instruction, so any stall it
  // would have caused is moot.
  assign branch_flush = ex_taken && vld_p0 && (branch_p0 != BR_NONE);
  assign flush        = branch_flush;
  assign stall        = hazard_stall && !branch_flush;
  assign issue        = id_valid && dec_vld && !hazard_stall && !branch_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0        <= 1'b0;
      alu_op_p0     <= '0;
      alu_src_p0    <= 1'b0;
      branch_p0     <= BR_NONE;
      rd_p0         <= '0;
      reg_write_p0  <= 1'b0;
      mem_read_p0   <= 1'b0;
      mem_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 1'b0;
      vld_p1        <= 1'b0;
      rd_p1         <= '0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      rd_p2         <= '0;
      reg_write_p2  <= 1'b0;
      mem_to_reg_p2 <= 1'b0;
    end else begin
      // ID -> EX: a bubble (all controls 0) replaces anything not issued
      vld_p0        <= issue;
      alu_op_p0     <= issue ? dec_alu_op : '0;
      alu_src_p0    <= issue && dec_alu_src;
      branch_p0     <= issue ? dec_branch : BR_NONE;
      rd_p0         <= id_rd;
      reg_write_p0  <= issue && dec_reg_write;
      mem_read_p0   <= issue && dec_mem_read;
      mem_write_p0  <= issue && dec_mem_write;
      mem_to_reg_p0 <= issue && dec_mem_to_reg;
      // EX -> MEM
      vld_p1        <= vld_p0;
      rd_p1         <= rd_p0;
      reg_write_p1  <= reg_write_p0;
      mem_read_p1   <= mem_read_p0;
      mem_write_p1  <= mem_write_p0;
      mem_to_reg_p1 <= mem_to_reg_p0;
      // MEM -> WB
      rd_p2         <= rd_p1;
      reg_write_p2  <= reg_write_p1;
      mem_to_reg_p2 <= mem_to_reg_p1;
    end
  end

`ifdef CTRL_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_p0 <= 2'd0;
      fwd_b_p0 <= 2'd0;
    end else begin
      // ID -> EX
      fwd_a_p0 <= issue ? fwd_a_nxt : 2'd0;
      fwd_b_p0 <= issue ? fwd_b_nxt : 2'd0;
    end
  end

  assign fwd_a = fwd_a_p0;
  assign fwd_b = fwd_b_p0;
`endif

  assign ex_valid      = vld_p0;
  assign ex_alu_op     = alu_op_p0;
  assign ex_alu_src    = alu_src_p0;
  assign ex_branch     = branch_p0;
  assign ex_rd         = rd_p0;
  assign mem_read      = mem_read_p1;
  assign mem_write     = mem_write_p1;
  assign mem_rd        = rd_p1;
  assign mem_reg_write = reg_write_p1;
  assign wb_reg_write  = reg_write_p2;
  assign wb_mem_to_reg = mem_to_reg_p2;
  assign wb_rd         = rd_p2;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: directed instruction sequences with
// hand-computed stall/flush and control expectations, checked by a
// scoreboard monitor on the falling clock edge.
module tb_pipe_ctrl_unit;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLT = 4'd5,  OP_ADDI = 4'd6, OP_ANDI = 4'd7;
  localparam logic [3:0] OP_ORI = 4'd8,  OP_XORI = 4'd9, OP_LW = 4'd10,  OP_SW = 4'd11;
  localparam logic [3:0] OP_BEQ = 4'd12, OP_BNE = 4'd13, OP_J = 4'd14,   OP_JAL = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       ex_taken;
  logic       stall, flush, ex_valid, ex_alu_src;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_branch;
  logic [2:0] ex_rd, mem_rd, wb_rd;
  logic       mem_read, mem_write, mem_reg_write, wb_reg_write, wb_mem_to_reg;
`ifdef CTRL_FWD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_rd(ex_rd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
`ifdef CTRL_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  typedef struct packed {
    logic       vld;
    logic [3:0] alu_op;
    logic       alu_src;
    logic [1:0] branch;
    logic [2:0] rd;
    logic       reg_write, mem_read, mem_write, mem_to_reg;
    logic [1:0] fa, fb;
  } ctl_t;

  typedef struct packed { logic stall; logic flush; } sf_t;

  ctl_t nxt_q[$];
  sf_t  sf_q[$];
  ctl_t ex_e, mem_e, wb_e;
  sf_t  cur_sf;
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference decode table of the Ak-16b ISA.
  function automatic ctl_t dec(input logic [3:0] opc, input logic [2:0] rd,
                               input logic [1:0] fa, input logic [1:0] fb);
    ctl_t r;
    r = '0;
    r.vld = 1'b1; r.rd = rd; r.fa = fa; r.fb = fb;
    case (opc)
      OP_ADD:  begin r.reg_write = 1; r.alu_op = 4'd0; end
      OP_SUB:  begin r.reg_write = 1; r.alu_op = 4'd1; end
      OP_AND:  begin r.reg_write = 1; r.alu_op = 4'd2; end
      OP_OR:   begin r.reg_write = 1; r.alu_op = 4'd3; end
      OP_XOR:  begin r.reg_write = 1; r.alu_op = 4'd4; end
      OP_SLT:  begin r.reg_write = 1; r.alu_op = 4'd5; end
      OP_ADDI: begin r.reg_write = 1; r.alu_src = 1; r.alu_op = 4'd0; end
      OP_ANDI: begin r.reg_write = 1; r.alu_src = 1; r.alu_op = 4'd2; end
      OP_ORI:  begin r.reg_write = 1; r.alu_src = 1; r.alu_op = 4'd3; end
      OP_XORI: begin r.reg_write = 1; r.alu_src = 1; r.alu_op = 4'd4; end
      OP_LW:   begin r.reg_write = 1; r.mem_read = 1; r.mem_to_reg = 1; r.alu_src = 1; end
      OP_SW:   begin r.mem_write = 1; r.alu_src = 1; end
      OP_BEQ:  begin r.branch = 2'd1; r.alu_op = 4'd1; end
      OP_BNE:  begin r.branch = 2'd2; r.alu_op = 4'd1; end
      OP_J:    begin r.branch = 2'd3; end
      default: begin r.branch = 2'd3; r.reg_write = 1; end
    endcase
    return r;
  endfunction

  // One clock of stimulus: drive ID, record the expected stall/flush for
  // this cycle and what should occupy EX after the next edge.
  task automatic step(input logic v, input logic [3:0] opc, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [2:0] rd, input logic tk,
                      input logic es, input logic ef,
                      input logic [1:0] fa = 2'd0, input logic [1:0] fb = 2'd0);
    @(posedge clk); #1;
    id_valid = v; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; ex_taken = tk;
    sf_q.push_back('{stall: es, flush: ef});
    if (v && !es && !ef) nxt_q.push_back(dec(opc, rd, fa, fb));
    else                 nxt_q.push_back('0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_flush"}, int'(flush), 0);
    chk({tag, "_ex_valid"}, int'(ex_valid), 0);
    chk({tag, "_ex_alu_op"}, int'(ex_alu_op), 0);
    chk({tag, "_ex_alu_src"}, int'(ex_alu_src), 0);
    chk({tag, "_ex_branch"}, int'(ex_branch), 0);
    chk({tag, "_ex_rd"}, int'(ex_rd), 0);
    chk({tag, "_mem_read"}, int'(mem_read), 0);
    chk({tag, "_mem_write"}, int'(mem_write), 0);
    chk({tag, "_mem_rd"}, int'(mem_rd), 0);
    chk({tag, "_mem_reg_write"}, int'(mem_reg_write), 0);
    chk({tag, "_wb_reg_write"}, int'(wb_reg_write), 0);
    chk({tag, "_wb_mem_to_reg"}, int'(wb_mem_to_reg), 0);
    chk({tag, "_wb_rd"}, int'(wb_rd), 0);
`ifdef CTRL_FWD_EN
    chk({tag, "_fwd_a"}, int'(fwd_a), 0);
    chk({tag, "_fwd_b"}, int'(fwd_b), 0);
`endif
  endtask

  // Scoreboard monitor: shadow pipeline of expected stage contents.
  always @(negedge clk) begin
    if (!rst_n) begin
      ex_e = '0; mem_e = '0; wb_e = '0;
      sf_q.delete(); nxt_q.delete();
    end else if (sf_q.size() != 0 && nxt_q.size() != 0) begin
      cur_sf = sf_q.pop_front();
      chk("stall", int'(stall), int'(cur_sf.stall));
      chk("flush", int'(flush), int'(cur_sf.flush));
      chk("ex_valid", int'(ex_valid), int'(ex_e.vld));
      chk("ex_alu_op", int'(ex_alu_op), int'(ex_e.alu_op));
      chk("ex_alu_src", int'(ex_alu_src), int'(ex_e.alu_src));
      chk("ex_branch", int'(ex_branch), int'(ex_e.branch));
      if (ex_e.vld) chk("ex_rd", int'(ex_rd), int'(ex_e.rd));
`ifdef CTRL_FWD_EN
      chk("fwd_a", int'(fwd_a), int'(ex_e.fa));
      chk("fwd_b", int'(fwd_b), int'(ex_e.fb));
`endif
      chk("mem_read", int'(mem_read), int'(mem_e.mem_read));
      chk("mem_write", int'(mem_write), int'(mem_e.mem_write));
      chk("mem_reg_write", int'(mem_reg_write), int'(mem_e.reg_write));
      if (mem_e.reg_write) chk("mem_rd", int'(mem_rd), int'(mem_e.rd));
      chk("wb_reg_write", int'(wb_reg_write), int'(wb_e.reg_write));
      chk("wb_mem_to_reg", int'(wb_mem_to_reg), int'(wb_e.mem_to_reg));
      if (wb_e.reg_write) chk("wb_rd", int'(wb_rd), int'(wb_e.rd));
      wb_e  = mem_e;
      mem_e = ex_e;
      ex_e  = nxt_q.pop_front();
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b1;
    id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_taken = 0;
    #1 rst_n = 1'b0;
    #2 reset_checks("por");
    @(negedge clk); #1 rst_n = 1'b1;

    // LW reaches EX, then reset is asserted mid-stream with a would-be
    // load-use instruction in ID.
    step(1, OP_LW, 3'd2, 3'd0, 3'd1, 0, 0, 0);
    drain(1);
    @(negedge clk); #1;
    id_valid = 1; id_opcode = OP_ADD; id_rs1 = 3'd1; id_rs2 = 3'd2; id_rd = 3'd5;
    rst_n = 1'b0;
    #1 reset_checks("mid");
    id_valid = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1, OP_ADD, 3'd1, 3'd2, 3'd5, 0, 0, 0);
    drain(4);

    // ADDI r1 ; ADD r2,r1,r3
    step(1, OP_ADDI, 3'd4, 3'd0, 3'd1, 0, 0, 0);
`ifdef CTRL_FWD_EN
    step(1, OP_ADD, 3'd1, 3'd3, 3'd2, 0, 0, 0, 2'd1, 2'd0);
`else
    step(1, OP_ADD, 3'd1, 3'd3, 3'd2, 0, 1, 0);
    step(1, OP_ADD, 3'd1, 3'd3, 3'd2, 0, 1, 0);
    step(1, OP_ADD, 3'd1, 3'd3, 3'd2, 0, 0, 0);
`endif
    drain(4);

    // LW r2 ; AND r4,r3,r2 (load-use)
    step(1, OP_LW, 3'd5, 3'd0, 3'd2, 0, 0, 0);
    step(1, OP_AND, 3'd3, 3'd2, 3'd4, 0, 1, 0);
`ifdef CTRL_FWD_EN
    step(1, OP_AND, 3'd3, 3'd2, 3'd4, 0, 0, 0, 2'd0, 2'd2);
`else
    step(1, OP_AND, 3'd3, 3'd2, 3'd4, 0, 1, 0);
    step(1, OP_AND, 3'd3, 3'd2, 3'd4, 0, 0, 0);
`endif
    drain(4);

    // LW r6 ; BEQ r0,r0 ; ADD r1,r6,r0 with BEQ taken -> flush beats stall
    step(1, OP_LW, 3'd5, 3'd0, 3'd6, 0, 0, 0);
    step(1, OP_BEQ, 3'd0, 3'd0, 3'd0, 0, 0, 0);
    step(1, OP_ADD, 3'd6, 3'd0, 3'd1, 1, 0, 1);
    step(1, OP_ADD, 3'd6, 3'd0, 3'd1, 0, 0, 0);
    step(1, OP_SUB, 3'd4, 3'd5, 3'd3, 1, 0, 0);   // taken ignored: EX not a branch
    drain(4);

    // ADD r0,r1,r2 ; SUB r3,r0,r0 -> r0 never a hazard
    step(1, OP_ADD, 3'd1, 3'd2, 3'd0, 0, 0, 0);
    step(1, OP_SUB, 3'd0, 3'd0, 3'd3, 0, 0, 0, 2'd0, 2'd0);
    drain(4);

    // SW ; LW back-to-back
    step(1, OP_SW, 3'd1, 3'd2, 3'd0, 0, 0, 0);
    step(1, OP_LW, 3'd1, 3'd0, 3'd3, 0, 0, 0);
    drain(4);

    // JAL r7 taken flushes XOR ; ORI r2 ; SLT r4,r2,r7
    step(1, OP_JAL, 3'd0, 3'd0, 3'd7, 0, 0, 0);
    step(1, OP_XOR, 3'd7, 3'd2, 3'd1, 1, 0, 1);
    step(1, OP_ORI, 3'd3, 3'd0, 3'd2, 0, 0, 0);
`ifdef CTRL_FWD_EN
    step(1, OP_SLT, 3'd2, 3'd7, 3'd4, 0, 0, 0, 2'd1, 2'd0);
`else
    step(1, OP_SLT, 3'd2, 3'd7, 3'd4, 0, 1, 0);
    step(1, OP_SLT, 3'd2, 3'd7, 3'd4, 0, 1, 0);
    step(1, OP_SLT, 3'd2, 3'd7, 3'd4, 0, 0, 0);
`endif
    drain(4);

    // BNE / J taken; ex_taken with an empty EX is ignored
    step(1, OP_BNE, 3'd1, 3'd2, 3'd0, 0, 0, 0);
    step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 1, 0, 1);
    step(1, OP_J, 3'd0, 3'd0, 3'd0, 1, 0, 0);
    step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 1, 0, 1);
    step(0, OP_ADD, 3'd0, 3'd0, 3'd0, 1, 0, 0);
    drain(4);

    // ADDI r1 ; ADDI r1 ; ADD r5,r1,r0 -> EX/MEM wins over MEM/WB
    step(1, OP_ADDI, 3'd4, 3'd0, 3'd1, 0, 0, 0);
    step(1, OP_ADDI, 3'd4, 3'd0, 3'd1, 0, 0, 0);
`ifdef CTRL_FWD_EN
    step(1, OP_ADD, 3'd1, 3'd0, 3'd5, 0, 0, 0, 2'd1, 2'd0);
`else
    step(1, OP_ADD, 3'd1, 3'd0, 3'd5, 0, 1, 0);
    step(1, OP_ADD, 3'd1, 3'd0, 3'd5, 0, 1, 0);
    step(1, OP_ADD, 3'd1, 3'd0, 3'd5, 0, 0, 0);
`endif
    drain(4);

    // Independent stream covering the remaining decodes
    step(1, OP_ANDI, 3'd2, 3'd0, 3'd1, 0, 0, 0);
    step(1, OP_OR,   3'd4, 3'd5, 3'd3, 0, 0, 0);
    step(1, OP_XORI, 3'd7, 3'd0, 3'd6, 0, 0, 0);
    step(1, OP_SUB,  3'd4, 3'd5, 3'd2, 0, 0, 0);
    drain(4);

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
